// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and parity helper.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 and ticks on the last cycle of each
// bit. Held at zero while clear is high so a new bit period starts cleanly.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) && !clear;

  // Counter wraps to zero at each bit boundary, or is forced to zero by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from an upstream FIFO: 8N1 frames, LSB first.
// Defining UART_TX_PARITY_EN adds an even parity bit (8E1, 11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  tx_state_t              state, state_d;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic [2:0]             bit_cnt, bit_cnt_d;
  logic                   txd_d;
  logic                   rd_req;
  logic                   baud_clr;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clr),
    .tick  (tick)
  );

  // Read strobe is suppressed during reset even though state already reads IDLE.
  assign fifo_rd = rd_req && !reset;
  assign busy    = (state != IDLE);

  // Next-state, datapath and strobe decode; txd is computed from the next
  // state so the registered line changes on the same edge as the state.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    rd_req    = 1'b0;
    tx_done   = 1'b0;
    baud_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state)
      IDLE: begin
        baud_clr = 1'b1;
        if (!fifo_empty) begin
          rd_req  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        baud_clr  = 1'b1;
        shreg_d   = fifo_data;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        parity_d  = even_parity(fifo_data);
`endif
        state_d   = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d   = {1'b0, shreg[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  // State, shift register, bit counter and registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      txd      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      txd      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at CLK_DIV=4 with a small FIFO model.
// Cycle 0 of each capture is the cycle in which fifo_rd is high.
module tb_uart_tx;

  localparam int unsigned CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int LAST = 45;
`else
  localparam int LAST = 41;
`endif
  localparam int NCAP = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = '0;
  logic       fifo_rd, txd, busy, tx_done;

  logic [7:0] q[$];
  int         qcount = 0;
  logic       tog_en = 1'b0;
  logic       tog = 1'b0;
  logic       rd_seen = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [NCAP-1:0] cap_txd, cap_busy, cap_done, cap_rd;

  assign fifo_empty = tog_en ? tog : (qcount == 0);

  uart_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Sample the read strobe mid low phase, pop on the following rising edge.
  always @(negedge clk) begin
    #2;
    rd_seen = fifo_rd;
  end

  always @(posedge clk) begin
    if (rd_seen && q.size() > 0) begin
      fifo_data <= q.pop_front();
      qcount    <= qcount - 1;
    end
  end

  // Noise on the FIFO flags/data while a frame is in flight.
  always @(negedge clk) begin
    if (tog_en) begin
      tog = ~tog;
      fifo_data <= 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    qcount <= qcount + 1;
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int c);
    if (c < 2)  return 1'b1;
    if (c < 6)  return 1'b0;
    if (c < 38) return b[(c-6)/4];
`ifdef UART_TX_PARITY_EN
    if (c < 42) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic capture(input bit do_tog);
    int n = 0;
    #1;
    while (!fifo_rd && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rd_timeout", {63'd0, fifo_rd}, 64'd1);
    for (int c = 0; c < NCAP; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (do_tog) begin
        if (c == 2)    tog_en = 1'b1;
        if (c == LAST) tog_en = 1'b0;
      end
      cap_txd[c]  = txd;
      cap_busy[c] = busy;
      cap_done[c] = tx_done;
      cap_rd[c]   = fifo_rd;
    end
  endtask

  task automatic check_frames(input string tag, input logic [7:0] b0,
                              input logic [7:0] b1, input bit two);
    logic [NCAP-1:0] e_txd, e_busy, e_done, e_rd;
    for (int c = 0; c < NCAP; c++) begin
      e_txd[c]  = (c <= LAST) ? frame_bit(b0, c) : (two ? frame_bit(b1, c-LAST-1) : 1'b1);
      e_busy[c] = (c == 0) ? 1'b0 : (c <= LAST) ? 1'b1 : (c == LAST+1) ? 1'b0 : two;
      e_rd[c]   = (c == 0) || (two && c == LAST+1);
      e_done[c] = (c == LAST);
    end
    check({tag, "_txd"},  64'(cap_txd),  64'(e_txd));
    check({tag, "_busy"}, 64'(cap_busy), 64'(e_busy));
    check({tag, "_done"}, 64'(cap_done), 64'(e_done));
    check({tag, "_rd"},   64'(cap_rd),   64'(e_rd));
  endtask

  initial begin
    // Power-on reset values.
    repeat (2) @(negedge clk);
    #1;
    check("init_txd",  {63'd0, txd},     64'd1);
    check("init_busy", {63'd0, busy},    64'd0);
    check("init_rd",   {63'd0, fifo_rd}, 64'd0);
    check("init_done", {63'd0, tx_done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while idle with a byte already waiting: no read strobe allowed.
    reset = 1'b1;
    push(8'hA5);
    #1;
    check("rst_idle_txd",  {63'd0, txd},     64'd1);
    check("rst_idle_busy", {63'd0, busy},    64'd0);
    check("rst_idle_rd",   {63'd0, fifo_rd}, 64'd0);
    check("rst_idle_done", {63'd0, tx_done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    capture(1'b0);
    check_frames("a5", 8'hA5, 8'h00, 1'b0);

    // Back-to-back frames.
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    capture(1'b0);
    check_frames("b2b", 8'h00, 8'hFF, 1'b1);
    repeat (50) @(negedge clk);

    // FIFO flags and data wiggling throughout a frame.
    push(8'h3C);
    push(8'h81);
    capture(1'b1);
    check_frames("tog", 8'h3C, 8'h81, 1'b1);
    repeat (50) @(negedge clk);

    // Reset during data bit 3 (cycles 18-21) of 0x35; next byte 0xC3 follows.
    push(8'h35);
    push(8'hC3);
    #1;
    check("mid_rd", {63'd0, fifo_rd}, 64'd1);
    repeat (19) @(negedge clk);
    #1;
    check("mid_bit3", {63'd0, txd}, 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_txd",  {63'd0, txd},     64'd1);
    check("mid_rst_busy", {63'd0, busy},    64'd0);
    check("mid_rst_rd",   {63'd0, fifo_rd}, 64'd0);
    check("mid_rst_done", {63'd0, tx_done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    capture(1'b0);
    check_frames("after_rst", 8'hC3, 8'h00, 1'b0);

    // Odd and even parity bytes (plain 10-bit frames when parity is off).
    @(negedge clk);
    push(8'h07);
    capture(1'b0);
    check_frames("p07", 8'h07, 8'h00, 1'b0);
    @(negedge clk);
    push(8'h03);
    capture(1'b0);
    check_frames("p03", 8'h03, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-005 SHALL have port fifo_data, input, 8: upstream FIFO read data, valid the cycle after fifo_rd.
REQ-006 SHALL have port fifo_rd, output, 1: one-cycle read strobe to the FIFO.
REQ-007 SHALL have port txd, output, 1: serial line, idle high.
REQ-008 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-009 SHALL have port tx_done, output, 1: one-cycle pulse in the last cycle of each stop bit.

Function
REQ-010 SHALL implement the states IDLE, FETCH, START, DATA, PARITY and STOP; PARITY exists only per REQ-024.
REQ-011 SHALL assert fifo_rd combinationally as (state==IDLE && !fifo_empty), and SHALL move to FETCH on the same edge.
REQ-012 SHALL, in FETCH, load fifo_data into an 8-bit shift register, clear the baud and bit counters, and move to START after exactly one cycle.
REQ-013 SHALL drive txd=0 for CLK_DIV cycles in START.
REQ-014 SHALL, in DATA, transmit 8 bits LSB first, each held for exactly CLK_DIV cycles, using a 3-bit bit counter.
REQ-015 SHALL drive txd=1 for CLK_DIV cycles in STOP, pulse tx_done in the last STOP cycle, then return to IDLE.
REQ-016 SHALL produce a first txd falling edge 2 cycles after the cycle in which fifo_rd is asserted (rd cycle, FETCH cycle, then START).
REQ-017 SHALL have a back-to-back frame period of 2 + 10*CLK_DIV cycles (2 + 11*CLK_DIV with parity), with busy low for exactly one cycle between frames.
REQ-018 SHALL never assert fifo_rd while busy; fifo_empty and fifo_data are ignored outside IDLE and FETCH respectively.
REQ-019 SHALL size the baud counter to $clog2(CLK_DIV) bits, wrapping from CLK_DIV-1 to 0 at each bit boundary with no off-by-one drift.
REQ-020 SHALL register txd, so it is free of combinational glitches.

Reset
REQ-021 SHALL, on reset assertion, immediately force state=IDLE, txd=1, busy=0, tx_done=0, fifo_rd=0, and all counters and the shift register to 0.
REQ-022 SHALL abandon any byte in flight when reset is asserted mid-frame; the byte is not re-read.
REQ-023 SHALL allow, after reset release, the first fifo_rd no earlier than the first rising edge with reset low.

Configuration
REQ-024 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA that drives even parity (XOR of the 8 data bits) for CLK_DIV cycles before STOP, giving an 11-bit frame.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or logic and use a 10-bit frame.

Structure
REQ-026 SHALL place the state enum type (tx_state_t) and the constants DATA_BITS=8, IDLE_LEVEL=1 in shared package uart_pkg.
REQ-027 SHALL instantiate one sub-module, uart_baud_gen (CLK_DIV counter with clear input and tick output), which the receiver also reuses.

Verification (CLK_DIV=4)
REQ-028 SHALL cover: reset asserted mid-idle -> txd=1, busy=0, fifo_rd=0, tx_done=0 asynchronously.
REQ-029 SHALL cover: single byte 0xA5, fifo_empty falls at cycle 0 -> fifo_rd high at cycle 0 only; txd=0 for cycles 2-5; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop bit at cycles 38-41; tx_done at cycle 41.
REQ-030 SHALL cover: FIFO holding 0x00 then 0xFF -> second fifo_rd at cycle 42, busy low only at cycle 42, second start bit at cycle 44.
REQ-031 SHALL cover: fifo_empty toggled throughout a frame -> no fifo_rd until the frame completes; the transmitted byte is unchanged.
REQ-032 SHALL cover: reset pulse during data bit 3 -> txd=1 immediately; after release with FIFO non-empty, a clean frame starts with the next byte.
REQ-033 SHALL cover, with UART_TX_PARITY_EN: 0x07 -> parity bit 1, 0x03 -> parity bit 0; tx_done at cycle 45.
